// File: rtl/amo_arb_pkg.sv
// amo_port_arbiter shared definitions.
// FSM encodings and AMO field width.
package amo_arb_pkg;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam int AMO_TYPE_W = 5;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Rotates the request vector by ptr so the first set bit is the winner.
module rr_pick
   import amo_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic [N-1:0]  rot;
   logic [IW-1:0] off;
   int            sum;

   // Doubling the vector turns the wrap-around scan into a plain shift.
   always_comb rot = N'({req, req} >> ptr);

   always_comb begin
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = IW'(i);
      end
   end

   always_comb begin
      sum = int'(ptr) + int'(off);
      if (sum >= N) sum = sum - N;
   end

   assign any        = |req;
   assign gnt_idx    = IW'(sum);
   assign gnt_onehot = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/amo_port_arbiter.sv
// Round-robin arbiter sharing the atomic unit port among N cores.
// One transaction at a time; grant held until downstream done.
module amo_port_arbiter
   import amo_arb_pkg::*;
#(
   parameter int N      = 2,
   parameter int XLEN   = 32,
   parameter int CLSIZE = 128
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [N-1:0]            core_strobe_i,
   input  logic [N*XLEN-1:0]       core_addr_i,
   input  logic [N-1:0]            core_rw_i,
   input  logic [N*CLSIZE-1:0]     core_data_i,
   input  logic [N-1:0]            core_is_amo_i,
   input  logic [N*AMO_TYPE_W-1:0] core_amo_type_i,
   output logic [N-1:0]            core_done_o,
   output logic [CLSIZE-1:0]       core_data_o,
   output logic [N-1:0]            au_core_id_o,
   output logic                    au_strobe_o,
   output logic [XLEN-1:0]         au_addr_o,
   output logic                    au_rw_o,
   output logic [CLSIZE-1:0]       au_data_o,
   output logic                    au_is_amo_o,
   output logic [AMO_TYPE_W-1:0]   au_amo_type_o,
   input  logic                    au_done_i,
   input  logic [CLSIZE-1:0]       au_data_i
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [0:0]    state;
   logic [N-1:0]  grant;
   logic [IW-1:0] prio_ptr;
   logic [IW-1:0] win_idx;

   logic [N-1:0]  pick_oh;
   logic [IW-1:0] pick_idx;
   logic          pick_any;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req        (core_strobe_i),
      .ptr        (prio_ptr),
      .gnt_onehot (pick_oh),
      .gnt_idx    (pick_idx),
      .any        (pick_any)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         grant    <= '0;
         prio_ptr <= '0;
         win_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state   <= BUSY;
                  grant   <= pick_oh;
                  win_idx <= pick_idx;
               end
            end
            BUSY: begin
               if (au_done_i) begin
                  state    <= IDLE;
                  grant    <= '0;
                  prio_ptr <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

   // grant is zero in IDLE, so every mux below yields 0 there.
   always_comb begin
      au_addr_o     = '0;
      au_rw_o       = 1'b0;
      au_data_o     = '0;
      au_is_amo_o   = 1'b0;
      au_amo_type_o = '0;
      for (int k = 0; k < N; k++) begin
         au_addr_o     |= core_addr_i[k*XLEN +: XLEN] & {XLEN{grant[k]}};
         au_rw_o       |= core_rw_i[k] & grant[k];
         au_data_o     |= core_data_i[k*CLSIZE +: CLSIZE] & {CLSIZE{grant[k]}};
         au_is_amo_o   |= core_is_amo_i[k] & grant[k];
         au_amo_type_o |= core_amo_type_i[k*AMO_TYPE_W +: AMO_TYPE_W]
                          & {AMO_TYPE_W{grant[k]}};
      end
   end

   assign au_strobe_o  = |(core_strobe_i & grant);
   assign au_core_id_o = grant;
   assign core_done_o  = (state == BUSY && au_done_i) ? grant : '0;
   assign core_data_o  = au_data_i;

endmodule

// File: tb/tb_amo_port_arbiter.sv
// Directed bench for amo_port_arbiter with N=2.
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_amo_port_arbiter;

   localparam int N  = 2;
   localparam int XL = 32;
   localparam int CL = 128;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic [N-1:0]    core_strobe_i = '0;
   logic [N*XL-1:0] core_addr_i;
   logic [N-1:0]    core_rw_i;
   logic [N*CL-1:0] core_data_i;
   logic [N-1:0]    core_is_amo_i;
   logic [N*5-1:0]  core_amo_type_i;
   logic [N-1:0]    core_done_o;
   logic [CL-1:0]   core_data_o;
   logic [N-1:0]    au_core_id_o;
   logic            au_strobe_o;
   logic [XL-1:0]   au_addr_o;
   logic            au_rw_o;
   logic [CL-1:0]   au_data_o;
   logic            au_is_amo_o;
   logic [4:0]      au_amo_type_o;
   logic            au_done_i = 1'b0;
   logic [CL-1:0]   au_data_i = '0;

   int tests = 0;
   int fails = 0;

   amo_port_arbiter #(.N(N), .XLEN(XL), .CLSIZE(CL)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .core_strobe_i   (core_strobe_i),
      .core_addr_i     (core_addr_i),
      .core_rw_i       (core_rw_i),
      .core_data_i     (core_data_i),
      .core_is_amo_i   (core_is_amo_i),
      .core_amo_type_i (core_amo_type_i),
      .core_done_o     (core_done_o),
      .core_data_o     (core_data_o),
      .au_core_id_o    (au_core_id_o),
      .au_strobe_o     (au_strobe_o),
      .au_addr_o       (au_addr_o),
      .au_rw_o         (au_rw_o),
      .au_data_o       (au_data_o),
      .au_is_amo_o     (au_is_amo_o),
      .au_amo_type_o   (au_amo_type_o),
      .au_done_i       (au_done_i),
      .au_data_i       (au_data_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // The granted core must hold its strobe until done.
   always @(posedge clk_i) begin
      if (rst_ni && au_core_id_o != '0 && !au_done_i &&
          (core_strobe_i & au_core_id_o) == '0) begin
         fails++;
         $display("FAIL proto: granted core %b dropped strobe", au_core_id_o);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [CL-1:0] act,
                      input logic [CL-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Static per-core configuration used by the vector table.
   function automatic logic [XL-1:0] e_addr(input logic [1:0] id);
      case (id)
         2'b01:   return 32'h100;
         2'b10:   return 32'h200;
         default: return '0;
      endcase
   endfunction

   function automatic logic [CL-1:0] e_wdata(input logic [1:0] id);
      case (id)
         2'b01:   return {8'hAB, 120'h0};
         2'b10:   return 128'h5;
         default: return '0;
      endcase
   endfunction

   function automatic logic [4:0] e_type(input logic [1:0] id);
      return (id == 2'b01) ? 5'b00010 : 5'b00000;
   endfunction

   task automatic cfg_default();
      core_addr_i     = {32'h200, 32'h100};
      core_rw_i       = 2'b01;
      core_data_i     = {128'h5, 8'hAB, 120'h0};
      core_is_amo_i   = 2'b10;
      core_amo_type_i = {5'b00000, 5'b00010};
   endtask

   task automatic do_reset();
      rst_ni        = 1'b0;
      core_strobe_i = '0;
      au_done_i     = 1'b0;
      au_data_i     = '0;
      tick();
      tick();
      chk("rst strobe", au_strobe_o, 0);
      chk("rst id", au_core_id_o, 0);
      chk("rst done", core_done_o, 0);
      chk("rst addr", au_addr_o, 0);
      chk("rst wdata", au_data_o, 0);
      rst_ni = 1'b1;
   endtask

   // Wait for au_strobe_o, check the grant, answer with done.
   task automatic serve(input string nm, input logic [1:0] id,
                        input logic [XL-1:0] addr, input logic [CL-1:0] rd,
                        input int lat);
      int n;
      n = 0;
      while (au_strobe_o !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      if (au_strobe_o !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL %s timeout: au_strobe_o=%b expected 1", nm, au_strobe_o);
         return;
      end
      if (lat >= 0) chk({nm, " lat"}, n, lat);
      chk({nm, " id"}, au_core_id_o, id);
      chk({nm, " addr"}, au_addr_o, addr);
      au_done_i = 1'b1;
      au_data_i = rd;
      #1;
      chk({nm, " done"}, core_done_o, id);
      chk({nm, " rdata"}, core_data_o, rd);
      tick();
      au_done_i = 1'b0;
      #1;
      chk({nm, " gap"}, au_strobe_o, 0);
      chk({nm, " gapdone"}, core_done_o, 0);
   endtask

   typedef struct {
      logic [1:0]    stb;
      logic          done;
      logic [CL-1:0] rd;
      logic          e_stb;
      logic [1:0]    e_id;
      logic [1:0]    e_done;
   } vec_t;

   vec_t v[16];

   initial begin
      v[0]  = '{2'b01, 1'b0, 128'h0, 1'b0, 2'b00, 2'b00};
      v[1]  = '{2'b01, 1'b0, 128'h0, 1'b1, 2'b01, 2'b00};
      v[2]  = '{2'b01, 1'b0, 128'h0, 1'b1, 2'b01, 2'b00};
      v[3]  = '{2'b01, 1'b1, 128'h33, 1'b1, 2'b01, 2'b01};
      v[4]  = '{2'b00, 1'b0, 128'h0, 1'b0, 2'b00, 2'b00};
      v[5]  = '{2'b11, 1'b0, 128'h0, 1'b0, 2'b00, 2'b00};
      v[6]  = '{2'b11, 1'b0, 128'h0, 1'b1, 2'b10, 2'b00};
      v[7]  = '{2'b11, 1'b1, 128'h7, 1'b1, 2'b10, 2'b10};
      v[8]  = '{2'b01, 1'b0, 128'h0, 1'b0, 2'b00, 2'b00};
      v[9]  = '{2'b01, 1'b1, 128'h9, 1'b1, 2'b01, 2'b01};
      v[10] = '{2'b00, 1'b1, 128'hDD, 1'b0, 2'b00, 2'b00};
      v[11] = '{2'b00, 1'b0, 128'h0, 1'b0, 2'b00, 2'b00};
      v[12] = '{2'b10, 1'b0, 128'h0, 1'b0, 2'b00, 2'b00};
      v[13] = '{2'b10, 1'b0, 128'h0, 1'b1, 2'b10, 2'b00};
      v[14] = '{2'b10, 1'b1, 128'h4, 1'b1, 2'b10, 2'b10};
      v[15] = '{2'b00, 1'b0, 128'h0, 1'b0, 2'b00, 2'b00};

      cfg_default();
      do_reset();

      for (int i = 0; i < 16; i++) begin
         core_strobe_i = v[i].stb;
         au_done_i     = v[i].done;
         au_data_i     = v[i].rd;
         #1;
         chk($sformatf("v%0d strobe", i), au_strobe_o, v[i].e_stb);
         chk($sformatf("v%0d id", i), au_core_id_o, v[i].e_id);
         chk($sformatf("v%0d done", i), core_done_o, v[i].e_done);
         chk($sformatf("v%0d rdata", i), core_data_o, v[i].rd);
         chk($sformatf("v%0d addr", i), au_addr_o, e_addr(v[i].e_id));
         chk($sformatf("v%0d wdata", i), au_data_o, e_wdata(v[i].e_id));
         chk($sformatf("v%0d rw", i), au_rw_o, v[i].e_id == 2'b01);
         chk($sformatf("v%0d amo", i), au_is_amo_o, v[i].e_id == 2'b10);
         chk($sformatf("v%0d type", i), au_amo_type_o, e_type(v[i].e_id));
         tick();
      end
      core_strobe_i = '0;
      au_done_i     = 1'b0;

      // Single store, then prio_ptr=1 favours core1.
      do_reset();
      core_strobe_i = 2'b01;
      serve("st0", 2'b01, 32'h100, 128'h0, 1);
      core_strobe_i = 2'b11;
      serve("ptr1", 2'b10, 32'h200, 128'h7, 1);
      core_strobe_i = '0;

      // Both requesting continuously from reset.
      do_reset();
      core_strobe_i = 2'b11;
      serve("rr0", 2'b01, 32'h100, 128'h1, 1);
      serve("rr1", 2'b10, 32'h200, 128'h2, 1);
      serve("rr2", 2'b01, 32'h100, 128'h3, 1);
      core_strobe_i = '0;

      // LR on core0, then SC on core1 returning fail value 1.
      do_reset();
      core_addr_i     = {32'h300, 32'h300};
      core_is_amo_i   = 2'b11;
      core_amo_type_i = {5'b00011, 5'b00010};
      core_strobe_i   = 2'b01;
      #1;
      chk("lr type", au_amo_type_o, 0);
      serve("lr", 2'b01, 32'h300, 128'h55, 1);
      core_strobe_i = 2'b10;
      tick();
      chk("sc type", au_amo_type_o, 5'b00011);
      serve("sc", 2'b10, 32'h300, 128'h1, -1);
      core_strobe_i = '0;
      cfg_default();

      // Reset asserted while BUSY clears outputs without a clock edge.
      do_reset();
      core_strobe_i = 2'b10;
      tick();
      chk("mid busy id", au_core_id_o, 2'b10);
      au_done_i = 1'b1;
      #1;
      rst_ni = 1'b0;
      #1;
      chk("mid rst strobe", au_strobe_o, 0);
      chk("mid rst id", au_core_id_o, 0);
      chk("mid rst done", core_done_o, 0);
      chk("mid rst addr", au_addr_o, 0);
      au_done_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      core_strobe_i = 2'b11;
      serve("post0", 2'b01, 32'h100, 128'hA, 1);
      serve("post1", 2'b10, 32'h200, 128'hB, 1);
      core_strobe_i = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
